// File: rtl/tinker_fetch_pkg.sv
// tinker_fetch_pkg: shared definitions for the instruction fetch queue.
//   FETCH_RESET_PC : default first fetch address after reset
//   FETCH_DEPTH    : default number of instruction queue entries
//   fetch_state_e  : fetch FSM state encoding
//   fetch_entry_t  : one queue entry {pc, word}
package tinker_fetch_pkg;

  localparam logic [63:0] FETCH_RESET_PC = 64'h2000;
  localparam int          FETCH_DEPTH    = 4;

  // RUN    : no request outstanding
  // WAIT   : request outstanding, returning word will be queued
  // DROP   : request outstanding, returning word will be thrown away
  // HALTED : fetching stopped until reset
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction queue with a registered head.
//   clk, reset   : clock, synchronous active-high reset
//   push         : write push_data at the tail
//   push_data    : entry to write
//   pop          : remove the head (ignored when empty)
//   flush        : empty the queue; wins over push and pop
//   head_valid   : head register holds a valid entry
//   head         : head entry (zero when empty)
//   count        : number of stored entries
// The caller guarantees push never happens while full.
module fetch_fifo
  import tinker_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             do_pop;

  assign do_pop = pop && head_valid_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_d       = '0;
    head_valid_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // The head register is loaded from the post-update storage so a push
    // into an empty queue is visible the cycle after the push edge.
    head_valid_d = (count_d != '0);
    if (head_valid_d) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head       = head_q;
  assign count      = count_q;

endmodule

// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue: sequential instruction fetcher feeding a small queue.
//   clk, reset          : clock, synchronous active-high reset
//   mem_req, mem_addr   : single outstanding instruction read request
//   mem_ack, mem_rdata  : one-cycle completion strobe with the fetched word
//   inst_valid/ready    : decoder handshake on the queue head; an entry is
//                         consumed on a cycle where both are high
//   inst_word, inst_pc  : head instruction and its address
//   redirect_valid/pc   : control-flow change; flushes queue, refetches
//   halt                : stop fetching once any outstanding request lands
//   dbg_state           : current fetch FSM state (fetch_state_e encoding)
//   dbg_count           : current queue occupancy
module tinker_fetch_queue
  import tinker_fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [63:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    mem_req,
  output logic [63:0]             mem_addr,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rdata,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst_word,
  output logic [63:0]             inst_pc,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_pc,
  input  logic                    halt,
  output logic [1:0]              dbg_state,
  output logic [$clog2(DEPTH):0]  dbg_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      req_addr_q, req_addr_d;
  logic             halt_pend_q, halt_pend_d;

  logic             redirect_live;
  logic [63:0]      redirect_target;
  logic             halting;
  logic             fifo_push;
  fetch_entry_t     fifo_push_data;
  logic             fifo_pop;
  logic             fifo_head_valid;
  fetch_entry_t     fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // HALTED ignores redirects entirely, including the flush.
  assign redirect_live   = redirect_valid && (state_q != ST_HALTED);
  assign redirect_target = redirect_pc & ~64'h3;
  // A halt seen while a request is in flight is remembered until it lands.
  assign halting         = halt || halt_pend_q;
  assign fifo_pop        = fifo_head_valid && inst_ready;

  always_comb begin
    state_d             = state_q;
    fetch_pc_d          = fetch_pc_q;
    req_addr_d          = req_addr_q;
    halt_pend_d         = halt_pend_q | halt;
    fifo_push           = 1'b0;
    fifo_push_data.pc   = req_addr_q;
    fifo_push_data.word = mem_rdata;

    case (state_q)
      ST_RUN: begin
        if (redirect_live) begin
          fetch_pc_d = redirect_target;
        end
        if (halting) begin
          state_d = ST_HALTED;
        end else if (redirect_live || (fifo_count < CNT_FULL)) begin
          // A redirect empties the queue this edge, so a slot is always free;
          // issue straight at the new target.
          req_addr_d = redirect_live ? redirect_target : fetch_pc_q;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_live) begin
          fetch_pc_d = redirect_target;
        end
        if (mem_ack) begin
          if (!redirect_live) begin
            fifo_push  = 1'b1;
            fetch_pc_d = req_addr_q + 64'd4;
          end
          state_d = halting ? ST_HALTED : ST_RUN;
        end else if (redirect_live) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (redirect_live) begin
          fetch_pc_d = redirect_target;
        end
        if (mem_ack) begin
          state_d = halting ? ST_HALTED : ST_RUN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (fifo_push_data),
    .pop        (fifo_pop),
    .flush      (redirect_live),
    .head_valid (fifo_head_valid),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // The request is held for as long as the FSM waits on it, so address and
  // strobe are stable until the ack edge.
  assign mem_req    = (state_q == ST_WAIT) || (state_q == ST_DROP);
  assign mem_addr   = req_addr_q;
  assign inst_valid = fifo_head_valid;
  assign inst_word  = fifo_head.word;
  assign inst_pc    = fifo_head.pc;
  assign dbg_state  = state_q;
  assign dbg_count  = fifo_count;

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// tb_tinker_fetch_queue: self-checking bench for tinker_fetch_queue.
// Every cycle: sample outputs on the falling edge, compare them against a
// transaction-level model (expected queue of {pc, word}), then drive inputs
// and advance the model on the rising edge.
module tb_tinker_fetch_queue;
  import tinker_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  tinker_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (64'h2000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int n_ack  = 0;

  // Reference model: what the fetcher should be doing, in transaction terms.
  logic [95:0] exp_q[$];          // {pc, word} the decoder should see, in order
  bit          m_busy;            // a request is outstanding
  bit          m_keep;            // its data is still wanted
  bit          m_halted;
  bit          m_pend;            // halt seen, not yet effective
  logic [63:0] m_fpc;             // next sequential fetch address
  logic [63:0] m_req_addr;        // address of the outstanding request

  logic [63:0] pop_pc_log[$];
  logic [31:0] pop_word_log[$];
  logic [63:0] req_log[$];        // DUT-observed address of each new request
  bit          req_new;

  bit          obs_req;
  logic [63:0] obs_addr;
  bit          obs_valid;
  logic [31:0] obs_word;
  logic [63:0] obs_pc;

  // ---------------- scoreboard / driver ----------------
  task automatic scoreboard_cycle();
    logic [95:0] e;
    @(negedge clk);
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    obs_valid = inst_valid;
    obs_word  = inst_word;
    obs_pc    = inst_pc;
    checks++;
    if (mem_req !== m_busy) begin
      errors++;
      $display("FAIL mem_req: got %b expected %b at %0t", mem_req, m_busy, $time);
    end
    if (m_busy) begin
      checks++;
      if (mem_addr !== m_req_addr) begin
        errors++;
        $display("FAIL mem_addr: got %h expected %h at %0t", mem_addr, m_req_addr, $time);
      end
    end
    checks++;
    if (inst_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL inst_valid: got %b expected %b at %0t", inst_valid, exp_q.size() != 0, $time);
    end
    if (exp_q.size() != 0 && inst_valid === 1'b1) begin
      e = exp_q[0];
      checks++;
      if (inst_pc !== e[95:32] || inst_word !== e[31:0]) begin
        errors++;
        $display("FAIL head: got pc %h word %h expected pc %h word %h at %0t",
                 inst_pc, inst_word, e[95:32], e[31:0], $time);
      end
    end
    if (mem_req === 1'b1 && req_new) req_log.push_back(mem_addr);
  endtask

  task automatic apply(input bit rdy, input bit ack, input logic [31:0] rdata,
                       input bit redir, input logic [63:0] rpc, input bit hlt);
    logic [95:0] e;
    int size_pre;
    bit haltnow;
    reset          = 1'b0;
    inst_ready     = rdy;
    mem_ack        = ack;
    mem_rdata      = rdata;
    redirect_valid = redir;
    redirect_pc    = rpc;
    halt           = hlt;
    req_new        = !(obs_req && !ack);
    @(posedge clk);
    size_pre = exp_q.size();
    if (exp_q.size() != 0 && rdy) begin
      e = exp_q.pop_front();
      pop_pc_log.push_back(e[95:32]);
      pop_word_log.push_back(e[31:0]);
    end
    if (!m_halted) begin
      haltnow = hlt || m_pend;
      m_pend  = m_pend || hlt;
      if (redir) begin
        exp_q.delete();
        m_fpc    = {rpc[63:2], 2'b00};
        size_pre = 0;
      end
      if (m_busy) begin
        if (redir) m_keep = 1'b0;
        if (ack) begin
          m_busy = 1'b0;
          if (m_keep) begin
            exp_q.push_back({m_req_addr, rdata});
            m_fpc = m_req_addr + 64'd4;
          end
          if (haltnow) m_halted = 1'b1;
        end
      end else if (haltnow) begin
        m_halted = 1'b1;
      end else if (size_pre < DEPTH) begin
        m_busy     = 1'b1;
        m_keep     = 1'b1;
        m_req_addr = m_fpc;
      end
    end
  endtask

  task automatic do_reset(input int cycles, input bit ack_during);
    @(negedge clk);
    reset          = 1'b1;
    mem_ack        = ack_during;
    mem_rdata      = 32'hDEAD_BEEF;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    repeat (cycles) @(posedge clk);
    exp_q.delete();
    pop_pc_log.delete();
    pop_word_log.delete();
    req_log.delete();
    m_busy   = 1'b0;
    m_keep   = 1'b0;
    m_halted = 1'b0;
    m_pend   = 1'b0;
    m_fpc    = 64'h2000;
    req_new  = 1'b1;
    n_ack    = 0;
  endtask

  // Memory that acks every request in the cycle it is seen.
  task automatic run_cycles(input int n, input bit rdy);
    bit ack;
    for (int i = 0; i < n; i++) begin
      scoreboard_cycle();
      ack = obs_req;
      apply(rdy, ack, 32'hAAAA_0000 + 32'(n_ack), 1'b0, 64'h0, 1'b0);
      if (ack) n_ack++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(2, 1'b1);
    scoreboard_cycle();
    checks++;
    if (obs_req !== 1'b0 || obs_addr !== 64'h2000) begin
      errors++;
      $display("FAIL reset_mem: got req %b addr %h expected 0 / 2000", obs_req, obs_addr);
    end
    checks++;
    if (obs_valid !== 1'b0 || obs_word !== 32'h0 || obs_pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_inst: got v %b w %h pc %h expected 0/0/0", obs_valid, obs_word, obs_pc);
    end
    apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    scoreboard_cycle();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 64'h2000) begin
      errors++;
      $display("FAIL first_req: got req %b addr %h expected 1 / 2000", obs_req, obs_addr);
    end
    apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    // Reset with a request outstanding and an ack arriving during reset.
    do_reset(1, 1'b1);
    scoreboard_cycle();
    // Stray ack right after reset, with no request outstanding.
    apply(1'b1, 1'b1, 32'h1234_5678, 1'b0, 64'h0, 1'b0);
    run_cycles(6, 1'b1);
    checks++;
    if (pop_pc_log.size() < 1 || pop_pc_log[0] !== 64'h2000 || pop_word_log[0] !== 32'hAAAA_0000) begin
      errors++;
      $display("FAIL reset_abandon: first pop pc/word wrong, pops=%0d", pop_pc_log.size());
    end
  endtask

  task automatic test_stream();
    do_reset(2, 1'b0);
    run_cycles(12, 1'b1);
    checks++;
    if (pop_pc_log.size() < 3) begin
      errors++;
      $display("FAIL stream_pops: got %0d pops expected >= 3", pop_pc_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_pc_log[i] !== 64'h2000 + 64'(4 * i) || pop_word_log[i] !== 32'hAAAA_0000 + 32'(i)) begin
          errors++;
          $display("FAIL stream_%0d: got pc %h word %h expected pc %h word %h", i,
                   pop_pc_log[i], pop_word_log[i], 64'h2000 + 64'(4 * i), 32'hAAAA_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_full();
    do_reset(2, 1'b0);
    run_cycles(20, 1'b0);
    scoreboard_cycle();
    checks++;
    if (n_ack !== 4 || obs_req !== 1'b0 || dbg_count !== 3'd4) begin
      errors++;
      $display("FAIL full: got reqs %0d req %b count %0d expected 4 / 0 / 4", n_ack, obs_req, dbg_count);
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    run_cycles(16, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_pc_log.size() <= i || pop_pc_log[i] !== 64'h2000 + 64'(4 * i)) begin
        errors++;
        $display("FAIL drain_%0d: got pops %0d expected pc %h in order", i, pop_pc_log.size(),
                 64'h2000 + 64'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 1'b0;
    int pidx;
    int ridx;
    do_reset(2, 1'b0);
    for (int i = 0; i < 40 && !found; i++) begin
      scoreboard_cycle();
      if (obs_req && obs_addr == 64'h2008) begin
        found = 1'b1;
        apply(1'b0, 1'b0, 32'h0, 1'b1, 64'h3003, 1'b0);
      end else begin
        apply(1'b0, obs_req, 32'hAAAA_0000 + 32'(n_ack), 1'b0, 64'h0, 1'b0);
        if (obs_req) n_ack++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_wait_reach: got no request at 2008 expected one within 40 cycles");
    end
    pidx = pop_pc_log.size();
    ridx = req_log.size();
    run_cycles(20, 1'b1);
    checks++;
    if (req_log.size() <= ridx || req_log[ridx] !== 64'h3000) begin
      errors++;
      $display("FAIL redir_wait_addr: got %0d new reqs expected first at 3000", req_log.size() - ridx);
    end
    checks++;
    if (pop_pc_log.size() <= pidx || pop_pc_log[pidx] !== 64'h3000) begin
      errors++;
      $display("FAIL redir_wait_pop: got %0d pops expected first pc 3000", pop_pc_log.size() - pidx);
    end
  endtask

  task automatic test_redirect_ack();
    bit found = 1'b0;
    do_reset(2, 1'b0);
    for (int i = 0; i < 10 && !found; i++) begin
      scoreboard_cycle();
      if (obs_req) begin
        found = 1'b1;
        apply(1'b1, 1'b1, 32'h5555_5555, 1'b1, 64'h4000, 1'b0);
      end else begin
        apply(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
      end
    end
    scoreboard_cycle();
    checks++;
    if (!found || obs_valid !== 1'b0 || dbg_count !== 3'd0) begin
      errors++;
      $display("FAIL redir_ack_push: got found %b valid %b count %0d expected 1 / 0 / 0",
               found, obs_valid, dbg_count);
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    scoreboard_cycle();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 64'h4000) begin
      errors++;
      $display("FAIL redir_ack_addr: got req %b addr %h expected 1 / 4000", obs_req, obs_addr);
    end
    apply(1'b1, 1'b1, 32'h0BAD_CAFE, 1'b0, 64'h0, 1'b0);
    run_cycles(6, 1'b1);
  endtask

  task automatic test_halt();
    bit found = 1'b0;
    int ridx;
    do_reset(2, 1'b0);
    for (int i = 0; i < 60 && !found; i++) begin
      scoreboard_cycle();
      if (obs_req && obs_addr == 64'h2010) begin
        found = 1'b1;
        apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
      end else begin
        apply(1'b1, obs_req, 32'hAAAA_0000 + 32'(n_ack), 1'b0, 64'h0, 1'b0);
        if (obs_req) n_ack++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL halt_reach: got no request at 2010 expected one within 60 cycles");
    end
    ridx = req_log.size();
    run_cycles(6, 1'b0);
    scoreboard_cycle();
    apply(1'b0, 1'b1, 32'h7777_7777, 1'b1, 64'h5000, 1'b0);
    scoreboard_cycle();
    checks++;
    if (dbg_state !== ST_HALTED || obs_req !== 1'b0 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_state: got state %0d req %b valid %b expected 3 / 0 / 1",
               dbg_state, obs_req, obs_valid);
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    run_cycles(8, 1'b1);
    checks++;
    if (req_log.size() != ridx || pop_pc_log.size() == 0 || pop_pc_log[pop_pc_log.size() - 1] !== 64'h2010) begin
      errors++;
      $display("FAIL halt_drain: got %0d new reqs, %0d pops expected 0 new reqs, last pop 2010",
               req_log.size() - ridx, pop_pc_log.size());
    end
    do_reset(1, 1'b0);
    scoreboard_cycle();
    checks++;
    if (obs_addr !== 64'h2000 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL halt_reset: got addr %h state %0d expected 2000 / 0", obs_addr, dbg_state);
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    run_cycles(4, 1'b1);
  endtask

  task automatic test_wrap();
    int ridx;
    do_reset(2, 1'b0);
    run_cycles(4, 1'b1);
    scoreboard_cycle();
    apply(1'b1, obs_req, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    ridx = req_log.size();
    run_cycles(12, 1'b1);
    checks++;
    if (req_log.size() < ridx + 2 || req_log[ridx] !== 64'hFFFF_FFFF_FFFF_FFFC || req_log[ridx + 1] !== 64'h0) begin
      errors++;
      $display("FAIL wrap: got %0d new reqs expected FFFFFFFFFFFFFFFC then 0", req_log.size() - ridx);
    end
  endtask

  task automatic test_random();
    bit rdy, ack, redir, hlt;
    int halt_at;
    do_reset(2, 1'b0);
    for (int i = 0; i < 800; i++) begin
      scoreboard_cycle();
      rdy   = ($urandom_range(0, 3) != 0);
      ack   = obs_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      redir = ($urandom_range(0, 24) == 0);
      apply(rdy, ack, $urandom, redir, {$urandom, $urandom}, 1'b0);
    end
    // Second phase: random traffic with a single halt somewhere inside.
    do_reset(1, 1'b0);
    halt_at = $urandom_range(10, 150);
    for (int i = 0; i < 200; i++) begin
      scoreboard_cycle();
      rdy   = ($urandom_range(0, 2) != 0);
      ack   = obs_req ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 9) == 0);
      redir = ($urandom_range(0, 19) == 0);
      hlt   = (i == halt_at);
      apply(rdy, ack, $urandom, redir, {$urandom, $urandom}, hlt);
    end
    checks++;
    if (dbg_state !== ST_HALTED || m_halted !== 1'b1) begin
      errors++;
      $display("FAIL random_halt: got state %0d model halted %b expected 3 / 1", dbg_state, m_halted);
    end
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    reset          = 1'b1;
    mem_ack        = 1'b0;
    mem_rdata      = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    halt           = 1'b0;
    obs_req        = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_ack();
    test_halt();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinker_fetch_queue.md
TINKER_FETCH_QUEUE -- requirements
Module: tinker_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, min 2).
REQ-002 The block SHALL have parameter RESET_PC, default 64'h2000, meaning first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port mem_req  output  1  instruction read request to memory.
REQ-006 The block SHALL have port mem_addr  output  64  byte address of requested instruction.
REQ-007 The block SHALL have port mem_ack  input  1  memory completion strobe, one cycle wide.
REQ-008 The block SHALL have port mem_rdata  input  32  instruction word, valid with mem_ack.
REQ-009 The block SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-010 The block SHALL have port inst_ready  input  1  decoder accepts head this cycle.
REQ-011 The block SHALL have port inst_word  output  32  head instruction word.
REQ-012 The block SHALL have port inst_pc  output  64  address of head instruction.
REQ-013 The block SHALL have port redirect_valid  input  1  control-flow change (branch/call/return taken).
REQ-014 The block SHALL have port redirect_pc  input  64  new fetch address.
REQ-015 The block SHALL have port halt  input  1  halt instruction retired; stop fetching.

Function
REQ-016 FSM states SHALL be RUN (no request outstanding), WAIT (request outstanding, result kept), DROP (request outstanding, result discarded), HALTED.
REQ-017 In RUN, with not halted and count < DEPTH, the block SHALL assert mem_req with mem_addr = fetch_pc and enter WAIT.
REQ-018 mem_req and mem_addr SHALL stay stable from assertion until the cycle mem_ack is sampled high; at most one request outstanding.
REQ-019 In WAIT, mem_ack SHALL push {fetch_pc, mem_rdata} into the queue, advance fetch_pc by 4 (mod 2^64 wrap), and return to RUN.
REQ-020 A pushed entry SHALL appear at inst_valid/inst_word/inst_pc the cycle after the ack edge when the queue was empty (1-cycle latency).
REQ-021 Pop SHALL occur only when inst_valid and inst_ready are both high; simultaneous push and pop SHALL keep count unchanged.
REQ-022 A request SHALL only be issued when count < DEPTH, so a push never finds the queue full; pushes when full SHALL be impossible by construction.
REQ-023 redirect_valid SHALL flush all entries (inst_valid low next cycle), set fetch_pc = {redirect_pc[63:2], 2'b00}, and move WAIT to DROP; RUN stays RUN.
REQ-024 In DROP, mem_ack SHALL discard mem_rdata, leave fetch_pc, and go to RUN; a further redirect in DROP SHALL update fetch_pc only.
REQ-025 Redirect and pop in the same cycle: redirect SHALL win; queue empty next cycle.
REQ-026 Redirect and mem_ack in the same cycle while in WAIT: the returning word SHALL be discarded and the FSM SHALL go to RUN.
REQ-027 halt high SHALL block new requests; an outstanding WAIT request SHALL complete and push; then HALTED. Queue SHALL continue to drain.
REQ-028 HALTED SHALL be sticky until reset and SHALL ignore redirect_valid and mem_ack.
REQ-029 mem_ack outside WAIT/DROP SHALL be ignored.

Reset
REQ-030 While reset is high at a clock edge: state RUN, fetch_pc = RESET_PC, count 0, pointers 0.
REQ-031 Reset values: mem_req 0, mem_addr RESET_PC, inst_valid 0, inst_word 0, inst_pc 0.
REQ-032 Reset mid-request SHALL abandon the outstanding request; a later mem_ack SHALL be ignored.
REQ-033 First mem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-034 Package tinker_fetch_pkg SHALL hold RESET_PC, default DEPTH, the FSM state enum and the queue entry struct {pc[63:0], word[31:0]}.
REQ-035 Storage SHALL be a sub-module fetch_fifo (synchronous push/pop/flush, count output, registered head).

Verification
REQ-036 Reset, ack every request 1 cycle later with 0xAAAA0000+n, inst_ready=1 -> inst_pc sequence 0x2000, 0x2004, 0x2008, matching words.
REQ-037 inst_ready=0, acks always available -> exactly DEPTH(4) requests, mem_req stays low, count 4; then ready=1 drains in order.
REQ-038 Redirect to 0x3003 while WAIT at 0x2008 -> that word dropped, next mem_addr 0x3000, first inst_pc 0x3000.
REQ-039 Redirect and mem_ack in the same cycle -> no push; next mem_addr = redirect target.
REQ-040 halt while WAIT at 0x2010 -> word at 0x2010 pushed, no further mem_req, redirect then ignored; reset -> mem_addr 0x2000.
REQ-041 redirect_pc 0xFFFF_FFFF_FFFF_FFFC -> second mem_addr 0x0 (wrap).
